// File: rtl/sched_pkg.sv
// Shared definitions for the tick scheduler: configuration mode encodings,
// the per-channel state type and the prescaler divide-ratio helper.
package sched_pkg;

    // Configuration mode field encodings (2'b11 is reserved and acts as stop).
    localparam logic [1:0] MODE_STOP     = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PERIODIC = 2'b10;

    // Channel state: a channel is either parked or counting down.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    // Number of clkin cycles per base tick.
    function automatic int calc_div(input int clk_freq, input int base_freq);
        return clk_freq / base_freq;
    endfunction

endpackage

// File: rtl/base_prescaler.sv
// Shared base-rate prescaler: divides clkin by DIV and emits a one-cycle
// base_tick pulse in the cycle the count sits at its last value.
module base_prescaler #(
    parameter int DIV = 10
) (
    input  logic clkin,
    input  logic rst,
    input  logic en,
    output logic base_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: advance while enabled, wrap after the last value, hold otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = cnt_q;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded straight from the count flop; gated by en so a frozen prescaler never ticks.
    assign base_tick = en && (cnt_q == LAST);

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: one shared base prescaler feeds NCH channel
// FSMs, each counting a programmable number of base ticks in stop, one-shot
// or periodic mode and emitting registered single-cycle tick pulses.
module tick_scheduler
    import sched_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BASE_FREQ = 1000,
    parameter int NCH       = 4,
    parameter int PW        = 16,
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clkin,
    input  logic           rst,
    input  logic           en,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [1:0]     cfg_mode,
    input  logic [PW-1:0]  cfg_period,
    input  logic [NCH-1:0] done_clr,
    output logic           base_tick,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] active,
    output logic [NCH-1:0] done,
    output logic           cfg_err
);

    localparam int DIV  = calc_div(CLK_FREQ, BASE_FREQ);
    localparam int CHW1 = CHW + 1;
    localparam logic [CHW1-1:0] NCH_W  = CHW1'(NCH);
    localparam logic [PW-1:0]   CNT_ONE = PW'(1);

    logic base_tick_s;
    logic cfg_run_s;
    logic cfg_zero_s;
    logic cfg_in_range_s;
    logic cfg_reject_s;
    logic cfg_err_q;
    logic cfg_err_d;

    base_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clkin     (clkin),
        .rst       (rst),
        .en        (en),
        .base_tick (base_tick_s)
    );

    assign base_tick = base_tick_s;

    // Decode the configuration write shared by all channels and flag rejected writes.
    always_comb begin
        cfg_run_s      = (cfg_mode == MODE_ONESHOT) || (cfg_mode == MODE_PERIODIC);
        cfg_zero_s     = (cfg_period == '0);
        cfg_in_range_s = ({1'b0, cfg_ch} < NCH_W);
        cfg_reject_s   = cfg_we && cfg_in_range_s && cfg_run_s && cfg_zero_s;
        cfg_err_d      = cfg_reject_s;
    end

    // Error pulse register: high for exactly one cycle after a rejected write.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_e     state_q;
        ch_state_e     state_d;
        logic [PW-1:0] cnt_q;
        logic [PW-1:0] cnt_d;
        logic [PW-1:0] period_q;
        logic [PW-1:0] period_d;
        logic          oneshot_q;
        logic          oneshot_d;
        logic          tick_q;
        logic          tick_d;
        logic          done_q;
        logic          done_d;
        logic          wr_s;

        // A write addressed to this channel that was not rejected.
        assign wr_s = cfg_we && cfg_in_range_s && (cfg_ch == CHW'(i)) && !cfg_reject_s;

        // Channel next state: writes take priority over (and discard) any expiry this cycle.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            period_d  = period_q;
            oneshot_d = oneshot_q;
            tick_d    = 1'b0;
            done_d    = done_q & ~done_clr[i];
            if (wr_s) begin
                if (cfg_run_s) begin
                    state_d   = RUN;
                    cnt_d     = cfg_period;
                    period_d  = cfg_period;
                    oneshot_d = (cfg_mode == MODE_ONESHOT);
                    done_d    = 1'b0;
                end else begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                end
            end else if ((state_q == RUN) && base_tick_s) begin
                if (cnt_q == CNT_ONE) begin
                    tick_d = 1'b1;
                    if (oneshot_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = period_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end

        // Channel registers with asynchronous active-low reset.
        always_ff @(posedge clkin or negedge rst) begin
            if (!rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                period_q  <= '0;
                oneshot_q <= 1'b0;
                tick_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                period_q  <= period_d;
                oneshot_q <= oneshot_d;
                tick_q    <= tick_d;
                done_q    <= done_d;
            end
        end

        assign tick[i]   = tick_q;
        assign active[i] = (state_q == RUN);
        assign done[i]   = done_q;
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed testbench for tick_scheduler with DIV=10, NCH=4, PW=8.
module tb_tick_scheduler;

    logic       clkin;
    logic       rst;
    logic       en;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_period;
    logic [3:0] done_clr;
    logic       base_tick;
    logic [3:0] tick;
    logic [3:0] active;
    logic [3:0] done;
    logic       cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    tick_scheduler #(
        .CLK_FREQ  (100),
        .BASE_FREQ (10),
        .NCH       (4),
        .PW        (8)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .en         (en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .done_clr   (done_clr),
        .base_tick  (base_tick),
        .tick       (tick),
        .active     (active),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    // Advance into the next cycle; inputs set afterwards are sampled at the following edge.
    task automatic clk1();
        @(posedge clkin);
        #2;
    endtask

    // Step until a cycle with base_tick high (bounded).
    task automatic wait_bt();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            clk1();
            #1;
            if (base_tick === 1'b1) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_bt: no base_tick within 20 cycles");
        end
    endtask

    task automatic stop_ch(input logic [1:0] ch);
        clk1();
        cfg_we = 1'b1; cfg_ch = ch; cfg_mode = 2'b00; cfg_period = 8'd0;
        clk1();
        cfg_we = 1'b0;
        #1;
        n_tests++;
        if (active[ch] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_ch%0d_active: got %b expected 0", ch, active[ch]);
        end
        n_tests++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_ch%0d_err: got %b expected 0", ch, cfg_err);
        end
    endtask

    task automatic test_reset();
        logic exp_b;
        repeat (3) clk1();
        #1;
        n_tests++;
        if ({base_tick, tick, active, done, cfg_err} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all 0", {base_tick, tick, active, done, cfg_err});
        end
        for (int c = 1; c <= 100; c++) begin
            clk1();
            if (c == 1) begin
                rst = 1'b1;
                en  = 1'b1;
            end
            #1;
            exp_b = ((c % 10) == 0);
            n_tests++;
            if (base_tick !== exp_b) begin
                n_fail++;
                $display("FAIL base_tick_c%0d: got %b expected %b", c, base_tick, exp_b);
            end
            n_tests++;
            if ({tick, active, done, cfg_err} !== 13'd0) begin
                n_fail++;
                $display("FAIL idle_outputs_c%0d: got %b expected 0", c, {tick, active, done, cfg_err});
            end
        end
    endtask

    task automatic test_periodic();
        logic exp_t;
        wait_bt();
        clk1();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'b10; cfg_period = 8'd3;
        for (int k = 1; k <= 95; k++) begin
            clk1();
            if (k == 1) cfg_we = 1'b0;
            #1;
            exp_t = (k == 30) || (k == 60) || (k == 90);
            n_tests++;
            if (tick[0] !== exp_t) begin
                n_fail++;
                $display("FAIL periodic_tick_k%0d: got %b expected %b", k, tick[0], exp_t);
            end
            n_tests++;
            if (active[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL periodic_active_k%0d: got %b expected 1", k, active[0]);
            end
        end
        stop_ch(2'd0);
    endtask

    task automatic test_oneshot();
        logic exp_t, exp_a, exp_d;
        wait_bt();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'b01; cfg_period = 8'd2;
        for (int k = 1; k <= 45; k++) begin
            clk1();
            if (k == 1) cfg_we = 1'b0;
            if (k == 30) done_clr = 4'b0010;
            if (k == 31) done_clr = 4'b0000;
            #1;
            exp_t = (k == 21);
            exp_a = (k <= 20);
            exp_d = (k >= 21) && (k <= 30);
            n_tests++;
            if ({tick[1], active[1], done[1]} !== {exp_t, exp_a, exp_d}) begin
                n_fail++;
                $display("FAIL oneshot_k%0d: got tick/active/done %b%b%b expected %b%b%b",
                         k, tick[1], active[1], done[1], exp_t, exp_a, exp_d);
            end
        end
    endtask

    task automatic test_cfg_err();
        clk1();
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'b01; cfg_period = 8'd0;
        #1;
        n_tests++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_early: got %b expected 0", cfg_err);
        end
        clk1();
        cfg_we = 1'b0;
        #1;
        n_tests++;
        if ({cfg_err, active[2]} !== 2'b10) begin
            n_fail++;
            $display("FAIL cfg_err_pulse: got err/active %b%b expected 10", cfg_err, active[2]);
        end
        clk1();
        #1;
        n_tests++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_single: got %b expected 0", cfg_err);
        end
        // Start ch2, then stop it with the reserved mode.
        cfg_we = 1'b1; cfg_mode = 2'b10; cfg_period = 8'd5;
        clk1();
        cfg_we = 1'b0;
        #1;
        n_tests++;
        if ({cfg_err, active[2]} !== 2'b01) begin
            n_fail++;
            $display("FAIL ch2_start: got err/active %b%b expected 01", cfg_err, active[2]);
        end
        cfg_we = 1'b1; cfg_mode = 2'b11; cfg_period = 8'd5;
        clk1();
        cfg_we = 1'b0;
        #1;
        n_tests++;
        if ({cfg_err, active[2], tick[2]} !== 3'b000) begin
            n_fail++;
            $display("FAIL ch2_reserved_stop: got err/active/tick %b%b%b expected 000", cfg_err, active[2], tick[2]);
        end
    endtask

    task automatic test_restart();
        logic exp_t;
        wait_bt();
        clk1();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'b10; cfg_period = 8'd2;
        for (int k = 1; k <= 75; k++) begin
            clk1();
            cfg_we = (k == 19);
            cfg_period = 8'd5;
            #1;
            if (k == 19) begin
                n_tests++;
                if (base_tick !== 1'b1) begin
                    n_fail++;
                    $display("FAIL restart_align: got base_tick %b expected 1", base_tick);
                end
            end
            exp_t = (k == 70);
            n_tests++;
            if ({tick[0], active[0]} !== {exp_t, 1'b1}) begin
                n_fail++;
                $display("FAIL restart_k%0d: got tick/active %b%b expected %b1", k, tick[0], active[0], exp_t);
            end
        end
        cfg_we = 1'b0;
        stop_ch(2'd0);
    endtask

    task automatic test_en_hold_and_reset();
        logic exp_t;
        wait_bt();
        clk1();
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_mode = 2'b10; cfg_period = 8'd2;
        for (int k = 1; k <= 50; k++) begin
            clk1();
            if (k == 1) cfg_we = 1'b0;
            en = !((k >= 5) && (k <= 29));
            #1;
            if (!en) begin
                n_tests++;
                if (base_tick !== 1'b0) begin
                    n_fail++;
                    $display("FAIL en_low_base_tick_k%0d: got %b expected 0", k, base_tick);
                end
            end
            exp_t = (k == 45);
            n_tests++;
            if ({tick[3], active[3]} !== {exp_t, 1'b1}) begin
                n_fail++;
                $display("FAIL en_hold_k%0d: got tick/active %b%b expected %b1", k, tick[3], active[3], exp_t);
            end
        end
        wait_bt();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({base_tick, tick, active, done, cfg_err} !== 14'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected all 0", {base_tick, tick, active, done, cfg_err});
        end
        repeat (2) clk1();
        rst = 1'b1;
        clk1();
        #1;
        n_tests++;
        if ({base_tick, tick, active, done, cfg_err} !== 14'd0) begin
            n_fail++;
            $display("FAIL post_reset: got %b expected all 0", {base_tick, tick, active, done, cfg_err});
        end
    endtask

    initial begin
        rst        = 1'b0;
        en         = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = 2'd0;
        cfg_mode   = 2'b00;
        cfg_period = 8'd0;
        done_clr   = 4'b0000;
        test_reset();
        test_periodic();
        test_oneshot();
        test_cfg_err();
        test_restart();
        test_en_hold_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel tick scheduler that shares one base-rate prescaler among NCH timing channels. Each channel has a programmable period in base ticks and a stop, one-shot or periodic mode, and produces single-cycle enable pulses. It sits between the system clock and the display, scan and stopwatch logic, and replaces per-consumer free-running dividers with one configured, sequenced resource.

## Interface
- CLK_FREQ, 50000000: clkin frequency in Hz.
- BASE_FREQ, 1000: base tick rate in Hz; DIV = CLK_FREQ/BASE_FREQ, with DIV ≥ 2 required.
- NCH, 4: number of channels, 1..8.
- PW, 16: period field width.
- clkin  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- en  in  1  global enable; when low, the prescaler and all channel counters hold.
- cfg_we  in  1  single-cycle configuration write strobe.
- cfg_ch  in  clog2(NCH)  target channel; out-of-range writes are ignored.
- cfg_mode  in  2  00 stop, 01 one-shot, 10 periodic, 11 reserved (treated as stop).
- cfg_period  in  PW  period in base ticks.
- done_clr  in  NCH  per-channel clear of the done flag.
- base_tick  out  1  one-cycle pulse at BASE_FREQ.
- tick  out  NCH  one-cycle pulse per channel expiry.
- active  out  NCH  channel is running.
- done  out  NCH  sticky: a one-shot has completed.
- cfg_err  out  1  one-cycle pulse: a write was rejected.

## Operation
- Reset values: all outputs 0, prescaler count 0, all channels IDLE, all counters 0.
- Prescaler: counts 0..DIV-1 while en=1. base_tick=1 in the cycle the count equals DIV-1; the count then wraps to 0.
- Channel FSM states:
  - IDLE -> RUN on a write with mode 01 or 10 and period ≥ 1. The counter loads the period and active=1.
  - RUN: the counter decrements on each base_tick. When it is 1 and a base_tick occurs, tick is asserted next cycle.
  - Periodic: reload the period and stay in RUN.
  - One-shot: go to IDLE, with active=0 and done=1 in the same cycle as tick.
- A write with mode 00 or 11 in any state -> IDLE, active=0, no tick; done is unchanged.
- A write with period=0 and mode 01/10 is rejected: cfg_err pulses and channel state is unchanged.
- A write to a RUN channel restarts it with the new mode and period. Any pending expiry in that same cycle is discarded, so no tick is produced.
- done set and done_clr in the same cycle: set wins. A valid run write to the channel also clears done.
- en=0: base_tick=0 and counters hold. Config writes are still accepted; the count starts when en returns.
- Period arithmetic is unsigned PW-bit. The maximum period is 2^PW-1 with no overflow, and the counter never goes below 1 in RUN.
- Multiple channels may tick in the same cycle; there is no arbitration between channels.

## Timing
- Write at cycle t: the first tick follows the P-th base_tick strictly after t, by one cycle.
- A base_tick in cycle t itself is not counted.
- Period P gives ticks spaced exactly P×DIV clkin cycles apart while en=1.
- Tick latency: 1 cycle after the expiring base_tick (registered output).
- active and done change in the same cycle as the one-shot tick.
- cfg_err is asserted 1 cycle after the offending cfg_we.
- Reset assertion mid-operation clears everything immediately (asynchronous). Deassertion takes effect on the next clkin edge.

## Structure
- Shared package sched_pkg holds:
  - mode encodings MODE_STOP, MODE_ONESHOT, MODE_PERIODIC;
  - the channel state enum IDLE/RUN;
  - the DIV computation function.
- One sub-module, base_prescaler (clkin, rst, en -> base_tick), instantiated once.
- Channel FSMs are generated NCH times inside tick_scheduler.

## Test plan
All scenarios use CLK_FREQ=100, BASE_FREQ=10 (DIV=10), NCH=4, PW=8.
- Reset, then en=1 for 100 cycles -> base_tick every 10 cycles, first at cycle 10. tick, active, done stay 0.
- Ch0 periodic P=3 -> ticks every 30 cycles, the first after the 3rd base_tick post-write. active=1 throughout.
- Ch1 one-shot P=2 -> exactly one tick. active falls and done rises in the tick cycle. done_clr[1] then clears done.
- Write ch2 period=0, mode 01 -> cfg_err pulses one cycle later, ch2 stays IDLE. Write mode 11 -> ch2 IDLE, no error.
- Ch0 running; rewrite ch0 P=5 in the cycle its expiry would occur -> no tick that cycle, next tick 5 base_ticks later.
- Ch3 running, en low for 25 cycles -> counter frozen and the tick is delayed by 25 cycles. Then rst=0 mid-count -> all outputs 0 immediately.
